// File: rtl/background_encoder_checker.sv
// background_encoder_checker
//   Read-side checker for MBIST data backgrounds. Each read word is encoded
//   back to a 3-bit background code, compared with the expected selector, and
//   pass/fail results are accumulated over one test session.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, stop           session open / close pulses (start wins)
//   rd_valid, rd_data,
//   rd_addr, exp_q        read word, its address and expected selector
//   code_valid, code,
//   code_legal, mismatch  registered per-read encode/compare result
//   busy, done, pass      session state: ACTIVE, HOLD, HOLD without failures
//   fail, fail_cnt        sticky failure flag, saturating mismatch count
//   first_fail_*          address/data/selector of the first mismatch
module background_encoder_checker #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        exp_q,
  output logic              code_valid,
  output logic [2:0]        code,
  output logic              code_legal,
  output logic              mismatch,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [7:0]        first_fail_data,
  output logic [2:0]        first_fail_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0] enc_code;
  logic       enc_legal;
  logic       enc_mismatch;
  logic       accum;

  always_comb begin
    enc_code  = 3'b111;
    enc_legal = 1'b1;
    case (rd_data)
      8'hAA:   enc_code = 3'b000;
      8'h55:   enc_code = 3'b001;
      8'hF0:   enc_code = 3'b010;
      8'h0F:   enc_code = 3'b011;
      8'h00:   enc_code = 3'b100;
      8'hFF:   enc_code = 3'b101;
      default: enc_legal = 1'b0;
    endcase
  end

  assign enc_mismatch = ~enc_legal | (exp_q > 3'd5) | (enc_code != exp_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACTIVE;
      ACTIVE:  if (!start && stop) state_nxt = HOLD;
      HOLD:    if (start) state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state == ACTIVE);
  assign done = (state == HOLD);
  assign pass = done & ~fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_valid <= 1'b0;
      code       <= '0;
      code_legal <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      code_valid <= rd_valid;
      if (rd_valid) begin
        code       <= enc_code;
        code_legal <= enc_legal;
        mismatch   <= enc_mismatch;
      end
    end
  end

  // A start pulse opens a fresh session in the same edge, so a read sampled
  // alongside start is folded into the cleared results rather than the old ones.
  assign accum = rd_valid & enc_mismatch & (start | (state == ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail            <= 1'b0;
      fail_cnt        <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
      first_fail_q    <= '0;
    end else if (start) begin
      fail            <= accum;
      fail_cnt        <= accum ? CNT_W'(1) : '0;
      first_fail_addr <= accum ? rd_addr : '0;
      first_fail_data <= accum ? rd_data : '0;
      first_fail_q    <= accum ? exp_q   : '0;
    end else if (accum) begin
      fail <= 1'b1;
      if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
      if (!fail) begin
        first_fail_addr <= rd_addr;
        first_fail_data <= rd_data;
        first_fail_q    <= exp_q;
      end
    end
  end

endmodule

// File: tb/tb_background_encoder_checker.sv
module tb_background_encoder_checker;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, stop, rd_valid;
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        exp_q;

  logic              code_valid, code_legal, mismatch, busy, done, pass, fail;
  logic [2:0]        code, first_fail_q;
  logic [7:0]        fail_cnt, first_fail_data;
  logic [ADDR_W-1:0] first_fail_addr;

  logic              s_code_valid, s_code_legal, s_mismatch, s_busy, s_done, s_pass, s_fail;
  logic [2:0]        s_code, s_first_fail_q;
  logic [1:0]        s_fail_cnt;
  logic [7:0]        s_first_fail_data;
  logic [ADDR_W-1:0] s_first_fail_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  background_encoder_checker #(.ADDR_W(ADDR_W), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr), .exp_q(exp_q),
    .code_valid(code_valid), .code(code), .code_legal(code_legal),
    .mismatch(mismatch), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_cnt(fail_cnt), .first_fail_addr(first_fail_addr),
    .first_fail_data(first_fail_data), .first_fail_q(first_fail_q)
  );

  background_encoder_checker #(.ADDR_W(ADDR_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr), .exp_q(exp_q),
    .code_valid(s_code_valid), .code(s_code), .code_legal(s_code_legal),
    .mismatch(s_mismatch), .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail),
    .fail_cnt(s_fail_cnt), .first_fail_addr(s_first_fail_addr),
    .first_fail_data(s_first_fail_data), .first_fail_q(s_first_fail_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s_start, input logic s_stop);
    start = s_start;
    stop  = s_stop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] d, input logic [ADDR_W-1:0] a, input logic [2:0] q);
    rd_valid = 1'b1;
    rd_data  = d;
    rd_addr  = a;
    exp_q    = q;
    tick();
    rd_valid = 1'b0;
  endtask

  logic [7:0] bg [6];

  initial begin
    bg[0] = 8'hAA; bg[1] = 8'h55; bg[2] = 8'hF0;
    bg[3] = 8'h0F; bg[4] = 8'h00; bg[5] = 8'hFF;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; rd_valid = 1'b0;
    rd_data = '0; rd_addr = '0; exp_q = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cv", code_valid, 0);
    chk("rst_cnt", fail_cnt, 0);
    rst_n = 1'b1;
    tick();

    // all six backgrounds, matching selectors
    pulse(1, 0);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      rd(bg[i], ADDR_W'(i), 3'(i));
      chk("t1_cv", code_valid, 1);
      chk("t1_code", code, i);
      chk("t1_legal", code_legal, 1);
      chk("t1_mis", mismatch, 0);
    end
    tick();
    chk("t1_cv_low", code_valid, 0);
    chk("t1_code_hold", code, 5);
    pulse(0, 1);
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_pass", pass, 1);
    chk("t1_cnt", fail_cnt, 0);

    // two failures, first-fail capture
    pulse(1, 0);
    chk("t2_busy", busy, 1);
    rd(8'h55, 10'd3, 3'd0);
    chk("t2_code0", code, 1);
    chk("t2_mis0", mismatch, 1);
    chk("t2_cnt0", fail_cnt, 1);
    chk("t2_fail", fail, 1);
    rd(8'h13, 10'd7, 3'd4);
    chk("t2_code1", code, 7);
    chk("t2_legal1", code_legal, 0);
    chk("t2_cnt1", fail_cnt, 2);
    chk("t2_ffa", first_fail_addr, 3);
    chk("t2_ffd", first_fail_data, 8'h55);
    chk("t2_ffq", first_fail_q, 0);
    pulse(0, 1);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);
    rd(8'h13, 10'd9, 3'd1);
    chk("t2_hold_cv", code_valid, 1);
    chk("t2_hold_cnt", fail_cnt, 2);

    // illegal selector on a legal background
    pulse(1, 0);
    chk("t4_clr_cnt", fail_cnt, 0);
    chk("t4_clr_ffa", first_fail_addr, 0);
    chk("t4_clr_fail", fail, 0);
    rd(8'hAA, 10'd9, 3'd6);
    chk("t4_code", code, 0);
    chk("t4_legal", code_legal, 1);
    chk("t4_mis", mismatch, 1);
    chk("t4_fail", fail, 1);
    chk("t4_ffq", first_fail_q, 6);

    // saturation on the CNT_W=2 instance
    pulse(1, 0);
    chk("t3_clr", s_fail_cnt, 0);
    for (int i = 1; i <= 5; i++) begin
      rd(8'h00, 10'(20 + i), 3'd0);
      chk("t3_sat_cnt", s_fail_cnt, (i > 3) ? 3 : i);
      chk("t3_wide_cnt", fail_cnt, i);
    end
    chk("t3_ffa", first_fail_addr, 21);

    // asynchronous reset mid-session
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_cnt", fail_cnt, 0);
    chk("t6_fail", fail, 0);
    chk("t6_ffa", first_fail_addr, 0);
    chk("t6_cv", code_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // read in IDLE is encoded but not accumulated
    rd(8'h01, 10'd5, 3'd2);
    chk("t5_idle_cv", code_valid, 1);
    chk("t5_idle_mis", mismatch, 1);
    chk("t5_idle_cnt", fail_cnt, 0);
    chk("t5_idle_busy", busy, 0);

    // start+stop together with a failing read
    start = 1'b1; stop = 1'b1;
    rd(8'hF0, 10'd11, 3'd3);
    start = 1'b0; stop = 1'b0;
    chk("t5_busy", busy, 1);
    chk("t5_done", done, 0);
    chk("t5_cnt", fail_cnt, 1);
    chk("t5_ffa", first_fail_addr, 11);

    // restart while ACTIVE clears, with a clean read in the same cycle
    start = 1'b1;
    rd(8'hFF, 10'd12, 3'd5);
    start = 1'b0;
    chk("t6_clean_cnt", fail_cnt, 0);
    chk("t6_clean_fail", fail, 0);
    chk("t6_clean_busy", busy, 1);
    pulse(0, 1);
    chk("t6_clean_pass", pass, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
